// File: rtl/pu_decode_stage_pkg.sv
// Shared types for the PU decode stage: decoded command layout, opcode map and stage FSM states.
package pu_decode_stage_pkg;

  localparam int unsigned DEC_XLEN = 32;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPI    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_AMO    = 5'b01011;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_END    = 5'b11100;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } dec_state_t;

  typedef struct packed {
    logic [4:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [4:0]          funct5;
    logic [DEC_XLEN-1:0] imm;
    logic                load;
    logic                store;
    logic                opi;
    logic                op;
    logic                lui;
    logic                auipc;
    logic                branch;
    logic                jal;
    logic                jalr;
    logic                atomic;
    logic                end_program;
    logic                take_branch;
  } dec_type;

  function automatic logic opc_known(input logic [4:0] opc);
    case (opc)
      OPC_LOAD, OPC_OPI, OPC_AUIPC, OPC_STORE, OPC_AMO, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_END: opc_known = 1'b1;
      default:                                         opc_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pu_decode_core.sv
// Combinational RV32 word -> dec_type decoder; illegal encodings come out as an all-zero command.
module pu_decode_core
  import pu_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = DEC_XLEN
) (
  input  logic [31:0] inst_i,
  output dec_type     cmd_o,
  output logic        illegal_o
);

  logic [4:0]      opc;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;

  always_comb begin
    cmd_o   = '0;
    imm_sel = '0;
    opc     = inst_i[6:2];
    f3      = inst_i[14:12];

    imm_i = XLEN'($signed(inst_i[31:20]));
    imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));
    imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));

    illegal_o = (inst_i[1:0] != 2'b11) || !opc_known(opc) ||
                ((opc == OPC_BRANCH) && (f3[2:1] == 2'b01));

    cmd_o.opcode = opc;
    cmd_o.rd     = inst_i[11:7];
    cmd_o.rs1    = inst_i[19:15];
    cmd_o.rs2    = inst_i[24:20];
    cmd_o.funct3 = f3;
    cmd_o.funct5 = inst_i[31:27];

    case (opc)
      OPC_LOAD:  begin cmd_o.load  = 1'b1; imm_sel = imm_i; end
      OPC_OPI:   begin cmd_o.opi   = 1'b1; imm_sel = imm_i; end
      OPC_AUIPC: begin cmd_o.auipc = 1'b1; imm_sel = imm_u; end
      OPC_STORE: begin cmd_o.store = 1'b1; imm_sel = imm_s; end
      OPC_AMO:   cmd_o.atomic = (f3 == 3'b010);
      OPC_OP:    cmd_o.op = 1'b1;
      OPC_LUI:   begin cmd_o.lui   = 1'b1; imm_sel = imm_u; end
      OPC_BRANCH: begin
        // ALU computes SUB/SLT/SLTU; take_branch=1 means "branch when the ALU result is zero"
        cmd_o.branch = 1'b1;
        imm_sel      = imm_b;
        case (f3[2:1])
          2'b00:   begin cmd_o.funct3 = 3'b000; cmd_o.funct5 = 5'b01000; end
          2'b10:   begin cmd_o.funct3 = 3'b010; cmd_o.funct5 = 5'b00000; end
          default: begin cmd_o.funct3 = 3'b011; cmd_o.funct5 = 5'b00000; end
        endcase
        cmd_o.take_branch = (f3[2:1] == 2'b00) ? ~f3[0] : f3[0];
      end
      OPC_JALR:  begin cmd_o.jalr = 1'b1; imm_sel = imm_i; end
      OPC_JAL:   begin cmd_o.jal  = 1'b1; imm_sel = imm_j; end
      OPC_END:   cmd_o.end_program = 1'b1;
      default:   ;
    endcase

    cmd_o.imm = DEC_XLEN'(imm_sel);
    if (illegal_o) cmd_o = '0;
  end

endmodule

// File: rtl/pu_decode_stage.sv
// Registered decode stage with a one-entry skid buffer, RUN/HALT intake control and a saturating hand-off count.
// Optional feature: define PU_DEC_ILLEGAL_TRAP_EN to flag illegal words and halt on them.
module pu_decode_stage
  import pu_decode_stage_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned XLEN      = DEC_XLEN,
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_inst,
  input  logic [PC_WIDTH-1:0]  in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output dec_type              out_cmd,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic                 out_illegal,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] dec_count
);

  dec_type new_cmd;
  logic    new_ill;
  logic    trap_ill;

  pu_decode_core #(.XLEN(XLEN)) u_core (
    .inst_i    (in_inst[31:0]),
    .cmd_o     (new_cmd),
    .illegal_o (new_ill)
  );

  if (IN_WIDTH > 32) begin : g_wide_inst
    logic unused_upper;
    assign unused_upper = ^in_inst[IN_WIDTH-1:32];
  end

`ifdef PU_DEC_ILLEGAL_TRAP_EN
  assign trap_ill = new_ill;
`else
  logic unused_ill;
  assign unused_ill = new_ill;
  assign trap_ill   = 1'b0;
`endif

  dec_state_t           state_q, state_d;
  logic                 main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  dec_type              main_cmd_q, main_cmd_d, skid_cmd_q, skid_cmd_d;
  logic [PC_WIDTH-1:0]  main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic                 main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept, hand_off;

  // Built only from registers (and rst), so out_ready never reaches in_ready combinationally.
  assign in_ready = !rst && (state_q == RUN) && !skid_vld_q;
  assign accept   = in_valid && in_ready;
  assign hand_off = main_vld_q && out_ready;

  always_comb begin
    state_d    = state_q;
    main_vld_d = main_vld_q;
    main_cmd_d = main_cmd_q;
    main_pc_d  = main_pc_q;
    main_ill_d = main_ill_q;
    skid_vld_d = skid_vld_q;
    skid_cmd_d = skid_cmd_q;
    skid_pc_d  = skid_pc_q;
    skid_ill_d = skid_ill_q;
    cnt_d      = cnt_q;

    // Main frees up when empty or handing off; skid has priority since it is older.
    if (!main_vld_q || out_ready) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_cmd_d = skid_cmd_q;
        main_pc_d  = skid_pc_q;
        main_ill_d = skid_ill_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) begin
          main_cmd_d = new_cmd;
          main_pc_d  = in_pc;
          main_ill_d = trap_ill;
        end
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_cmd_d = new_cmd;
      skid_pc_d  = in_pc;
      skid_ill_d = trap_ill;
    end

    if (accept && (new_cmd.end_program || trap_ill)) state_d = HALT;
    if (hand_off && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
      state_d    = RUN;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      main_vld_q <= 1'b0;
      main_cmd_q <= '0;
      main_pc_q  <= '0;
      main_ill_q <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_cmd_q <= '0;
      skid_pc_q  <= '0;
      skid_ill_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_vld_q <= main_vld_d;
      main_cmd_q <= main_cmd_d;
      main_pc_q  <= main_pc_d;
      main_ill_q <= main_ill_d;
      skid_vld_q <= skid_vld_d;
      skid_cmd_q <= skid_cmd_d;
      skid_pc_q  <= skid_pc_d;
      skid_ill_q <= skid_ill_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid   = main_vld_q;
  assign out_cmd     = main_cmd_q;
  assign out_pc      = main_pc_q;
  assign out_illegal = main_ill_q;
  assign halted      = (state_q == HALT);
  assign dec_count   = cnt_q;

endmodule

// File: tb/tb_pu_decode_stage.sv
// Directed self-checking bench for pu_decode_stage (counter narrowed to 2 bits to reach saturation).
module tb_pu_decode_stage;
  import pu_decode_stage_pkg::*;

  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [31:0]      in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  dec_type          out_cmd;
  logic [31:0]      out_pc;
  logic             out_illegal;
  logic             halted;
  logic [CNT_W-1:0] dec_count;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PU_DEC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  pu_decode_stage #(
    .IN_WIDTH  (32),
    .XLEN      (32),
    .PC_WIDTH  (32),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_cmd     (out_cmd),
    .out_pc      (out_pc),
    .out_illegal (out_illegal),
    .halted      (halted),
    .dec_count   (dec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_inst = '0; in_pc = '0;
    repeat (2) tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_checks++; if (out_cmd !== dec_type'('0)) begin n_fail++; $display("FAIL rst_out_cmd got %h exp 0", out_cmd); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_out_pc got %h exp 0", out_pc); end
    n_checks++; if ({out_illegal, halted} !== 2'b00) begin n_fail++; $display("FAIL rst_ill_halt got %b exp 00", {out_illegal, halted}); end
    n_checks++; if (dec_count !== 2'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", dec_count); end
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_addi();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h100;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b exp 1", out_valid); end
    n_checks++; if (out_cmd.opi !== 1'b1) begin n_fail++; $display("FAIL addi_opi got %b exp 1", out_cmd.opi); end
    n_checks++; if (out_cmd.imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_imm got %h exp ffffffff", out_cmd.imm); end
    n_checks++; if (out_cmd.rd !== 5'd1) begin n_fail++; $display("FAIL addi_rd got %0d exp 1", out_cmd.rd); end
    n_checks++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL addi_pc got %h exp 100", out_pc); end
    tick();
    n_checks++; if (dec_count !== 2'd1) begin n_fail++; $display("FAIL addi_count got %0d exp 1", dec_count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0020F463; in_pc = 32'h200;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got %b exp 1", in_ready); end
    n_checks++; if (out_cmd.funct3 !== 3'b011) begin n_fail++; $display("FAIL bgeu_funct3 got %b exp 011", out_cmd.funct3); end
    n_checks++; if (out_cmd.take_branch !== 1'b1) begin n_fail++; $display("FAIL bgeu_take got %b exp 1", out_cmd.take_branch); end
    n_checks++; if (out_cmd.imm !== 32'h8) begin n_fail++; $display("FAIL bgeu_imm got %h exp 8", out_cmd.imm); end
    in_inst = 32'h002081B3; in_pc = 32'h204;
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready2 got %b exp 0", in_ready); end
    n_checks++; if (out_pc !== 32'h200 || out_cmd.branch !== 1'b1) begin n_fail++; $display("FAIL b2b_hold1 got pc %h br %b exp 200 1", out_pc, out_cmd.branch); end
    in_inst = 32'h123452B7; in_pc = 32'h208;
    tick();
    n_checks++; if (in_ready !== 1'b0 || out_pc !== 32'h200 || out_cmd.funct3 !== 3'b011) begin n_fail++; $display("FAIL b2b_hold2 got rdy %b pc %h f3 %b exp 0 200 011", in_ready, out_pc, out_cmd.funct3); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_pc !== 32'h204 || out_cmd.op !== 1'b1 || out_cmd.rd !== 5'd3) begin n_fail++; $display("FAIL b2b_second got pc %h op %b rd %0d exp 204 1 3", out_pc, out_cmd.op, out_cmd.rd); end
    n_checks++; if (in_ready !== 1'b1 || dec_count !== 2'd2) begin n_fail++; $display("FAIL b2b_after1 got rdy %b cnt %0d exp 1 2", in_ready, dec_count); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_pc !== 32'h208 || out_cmd.lui !== 1'b1 || out_cmd.imm !== 32'h12345000) begin n_fail++; $display("FAIL b2b_third got pc %h lui %b imm %h exp 208 1 12345000", out_pc, out_cmd.lui, out_cmd.imm); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || dec_count !== 2'd3) begin n_fail++; $display("FAIL b2b_end got vld %b cnt %0d exp 0 3", out_valid, dec_count); end
  endtask

  task automatic test_end_halt();
    do_flush();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00000073; in_pc = 32'h300;
    tick();
    in_inst = 32'h00000013; in_pc = 32'h304;
    n_checks++; if (out_valid !== 1'b1 || out_cmd.end_program !== 1'b1) begin n_fail++; $display("FAIL end_emit got vld %b end %b exp 1 1", out_valid, out_cmd.end_program); end
    n_checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL end_halt got halt %b rdy %b exp 1 0", halted, in_ready); end
    repeat (2) tick();
    n_checks++; if (out_valid !== 1'b0 || dec_count !== 2'd1) begin n_fail++; $display("FAIL end_blocked got vld %b cnt %0d exp 0 1", out_valid, dec_count); end
    do_flush();
    n_checks++; if (halted !== 1'b0 || in_ready !== 1'b1 || dec_count !== 2'd0) begin n_fail++; $display("FAIL end_flush got halt %b rdy %b cnt %0d exp 0 1 0", halted, in_ready, dec_count); end
  endtask

  task automatic test_flush_collision();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h400;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h400) begin n_fail++; $display("FAIL fl_pre got vld %b pc %h exp 1 400", out_valid, out_pc); end
    in_pc = 32'h404; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || dec_count !== 2'd0) begin n_fail++; $display("FAIL fl_same got vld %b cnt %0d exp 0 0", out_valid, dec_count); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_lost got vld %b exp 0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0000007F; in_pc = 32'h500;
    tick();
    in_inst = 32'hFFF00093; in_pc = 32'h504;
    n_checks++; if (out_valid !== 1'b1 || out_cmd !== dec_type'('0)) begin n_fail++; $display("FAIL ill_nop got vld %b cmd %h exp 1 0", out_valid, out_cmd); end
    n_checks++; if (out_illegal !== TRAP || halted !== TRAP) begin n_fail++; $display("FAIL ill_flag got ill %b halt %b exp %b %b", out_illegal, halted, TRAP, TRAP); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== !TRAP) begin n_fail++; $display("FAIL ill_next got vld %b exp %b", out_valid, !TRAP); end
    if (!TRAP) begin
      n_checks++; if (out_pc !== 32'h504 || out_cmd.opi !== 1'b1) begin n_fail++; $display("FAIL ill_keep got pc %h opi %b exp 504 1", out_pc, out_cmd.opi); end
    end
    in_valid = 1'b1; in_inst = 32'h00002063; in_pc = 32'h508;
    do_flush();
    in_valid = 1'b1; in_inst = 32'h00002063;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_cmd.branch !== 1'b0 || out_illegal !== TRAP) begin n_fail++; $display("FAIL ill_br got br %b ill %b exp 0 %b", out_cmd.branch, out_illegal, TRAP); end
    do_flush();
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 5);
      in_inst  = 32'h00100093;
      in_pc    = 32'h600 + 32'(4 * i);
      tick();
      if (i >= 1) begin
        n_checks++; if (dec_count !== exp_cnt[i-1]) begin n_fail++; $display("FAIL sat_%0d got %0d exp %0d", i, dec_count, exp_cnt[i-1]); end
      end
    end
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00000073; in_pc = 32'h700;
    repeat (2) tick();
    n_checks++; if (out_valid !== 1'b1 || halted !== 1'b1) begin n_fail++; $display("FAIL stall_pre got vld %b halt %b exp 1 1", out_valid, halted); end
    rst = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_cmd !== dec_type'('0) || out_pc !== 32'h0) begin n_fail++; $display("FAIL rst2_out got vld %b cmd %h pc %h exp 0 0 0", out_valid, out_cmd, out_pc); end
    n_checks++; if (halted !== 1'b0 || in_ready !== 1'b0 || dec_count !== 2'd0 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL rst2_state got halt %b rdy %b cnt %0d ill %b exp 0 0 0 0", halted, in_ready, dec_count, out_illegal); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst2_after got rdy %b vld %b exp 1 0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_end_halt();
    test_flush_collision();
    test_illegal();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
